// File: rtl/pipe_stage_chain_if.sv
// Handshake and payload bundle for pipe_stage_chain: input side (in_*) and output side (out_*).
// master is the surrounding pipeline (drives in_valid/in_*/out_ready); slave is the chain itself.
interface pipe_stage_chain_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage valid/ready pipeline register chain with per-stage flush, stall and sticky halt.
// Define PIPE_COLLAPSE_EN for bubble collapsing; when undefined all stages advance in lockstep.
module pipe_stage_chain #(
    parameter int  DATA_W   = 128,
    parameter int  CTRL_W   = 16,
    parameter int  DEPTH    = 1,
    parameter int  HALT_BIT = CTRL_W - 1,
    localparam int OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    pipe_stage_chain_if.slave bus,
    input  logic [DEPTH-1:0]  flush,
    output logic [OCC_W-1:0]  occupancy,
    output logic              halted
);
    logic [DEPTH-1:0]  valid_reg;
    logic [CTRL_W-1:0] ctrl_reg [DEPTH];
    logic [DATA_W-1:0] data_reg [DEPTH];
    logic              halted_reg;

    logic [DEPTH-1:0]  ev;
    logic [DEPTH-1:0]  src_valid;
    logic [CTRL_W-1:0] src_ctrl [DEPTH];
    logic [DATA_W-1:0] src_data [DEPTH];
    logic [DEPTH:0]    acc;    // acc[i]: stage i loads from its source; acc[DEPTH]: output side drains
    logic [DEPTH-1:0]  ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_src
            assign ev[gi] = valid_reg[gi] & ~flush[gi];
            if (gi == 0) begin : g_head
                assign src_valid[gi] = bus.in_valid & ~halted_reg;
                assign src_ctrl[gi]  = bus.in_ctrl;
                assign src_data[gi]  = bus.in_data;
            end else begin : g_body
                assign src_valid[gi] = ev[gi-1];
                assign src_ctrl[gi]  = ctrl_reg[gi-1];
                assign src_data[gi]  = data_reg[gi-1];
            end
        end
    endgenerate

    // A flushed stage refuses its upstream neighbour so the neighbour's entry is held, not lost.
    always_comb begin
        acc   = '0;
        ready = '0;
`ifdef PIPE_COLLAPSE_EN
        acc[DEPTH] = bus.out_ready;
`else
        acc[DEPTH] = bus.out_ready | ~ev[DEPTH-1];
`endif
        for (int k = DEPTH - 1; k >= 0; k--) begin
`ifdef PIPE_COLLAPSE_EN
            ready[k] = ~ev[k] | acc[k+1];
`else
            ready[k] = acc[k+1];
`endif
            acc[k] = ready[k] & ~flush[k];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_reg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_reg[k] <= '0;
                data_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (flush[k]) begin
                    valid_reg[k] <= 1'b0;
                    ctrl_reg[k]  <= '0;
                end else if (acc[k]) begin
                    valid_reg[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        ctrl_reg[k] <= src_ctrl[k];
                        data_reg[k] <= src_data[k];
                    end else begin
                        ctrl_reg[k] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halted_reg <= 1'b0;
        end else if (ev[DEPTH-1] & bus.out_ready & ctrl_reg[DEPTH-1][HALT_BIT]) begin
            halted_reg <= 1'b1;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(valid_reg[k]);
        end
    end

    assign bus.in_ready  = acc[0] & ~halted_reg;
    assign bus.out_valid = ev[DEPTH-1];
    assign bus.out_ctrl  = ev[DEPTH-1] ? ctrl_reg[DEPTH-1] : '0;
    assign bus.out_data  = data_reg[DEPTH-1];
    assign halted        = halted_reg;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed boundary cases on DEPTH=3 and DEPTH=1 instances plus a
// randomized stream checked by a queue-based scoreboard and a monitor process.
module tb_pipe_stage_chain;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int D  = 3;
    localparam int HB = CW - 1;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    pipe_stage_chain_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();
    pipe_stage_chain_if #(.DATA_W(DW), .CTRL_W(CW)) bus1 ();
    logic [D-1:0] flush;
    logic [1:0]   occupancy;
    logic         halted;
    logic [0:0]   flush1;
    logic [0:0]   occ1;
    logic         halted1;

    pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(D), .HALT_BIT(HB)) u_dut (
        .CLK(CLK), .nRST(nRST), .bus(bus), .flush(flush), .occupancy(occupancy), .halted(halted)
    );
    pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1), .HALT_BIT(HB)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .bus(bus1), .flush(flush1), .occupancy(occ1), .halted(halted1)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted entries in order; the chain must emit exactly these, no sooner than D cycles later.
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic [31:0]   t;
    } ent_t;
    ent_t sb[$];
    ent_t mon_e;
    bit   sb_on = 1'b0;

    always @(negedge CLK) begin
        if (sb_on && nRST) begin
            chk("occupancy", 64'(occupancy), 64'(sb.size()));
`ifdef PIPE_COLLAPSE_EN
            chk("in_ready", 64'(bus.in_ready), 64'(bus.out_ready || (sb.size() < D)));
`else
            if (bus.out_ready) chk("in_ready", 64'(bus.in_ready), 64'(1));
`endif
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("out_without_entry", 64'(bus.out_valid), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_ctrl", 64'(bus.out_ctrl), 64'(mon_e.c));
                    chk("out_data", 64'(bus.out_data), 64'(mon_e.d));
                    chk("latency_ge_depth", 64'((cyc - int'(mon_e.t)) >= D), 64'(1));
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back('{c: bus.in_ctrl, d: bus.in_data, t: cyc});
        end
    end

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_ctrl    = '0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        flush          = '0;
        bus1.in_valid  = 1'b0;
        bus1.in_ctrl   = '0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;
        flush1         = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    logic [DW-1:0] dat [5];
    logic [CW-1:0] drain_exp [4];
    logic          exp_v;
    int            exp_occ;
    int            peak;
    int            xfers;
    int            lo;

    initial begin
        idle_inputs();
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_ctrl",  64'(bus.out_ctrl),  64'(0));
        chk("rst_out_data",  64'(bus.out_data),  64'(0));
        chk("rst_occupancy", 64'(occupancy),     64'(0));
        chk("rst_halted",    64'(halted),        64'(0));
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
        flush = 3'b001;
        #1 chk("rst_in_ready_flush0", 64'(bus.in_ready), 64'(0));

        // Five back-to-back entries through DEPTH=3 with no stall.
        do_reset();
        for (int i = 0; i < 5; i++) dat[i] = DW'($urandom);
        bus.out_ready = 1'b1;
        peak = 0;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (c < 5);
            bus.in_ctrl  = CW'(c + 1);
            bus.in_data  = dat[c % 5];
            @(negedge CLK);
            exp_v = (c >= 3 && c <= 7);
            chk("s_out_valid", 64'(bus.out_valid), 64'(exp_v));
            chk("s_out_ctrl", 64'(bus.out_ctrl), exp_v ? 64'(c - 2) : 64'(0));
            if (exp_v) chk("s_out_data", 64'(bus.out_data), 64'(dat[c - 3]));
            lo = (c < 8) ? c : 8;
            exp_occ = ((c < 5) ? c : 5) - ((lo > 3) ? lo - 3 : 0);
            chk("s_occupancy", 64'(occupancy), 64'(exp_occ));
            if (int'(occupancy) > peak) peak = int'(occupancy);
            @(posedge CLK); #1;
        end
        chk("s_peak_occ", 64'(peak), 64'(3));

        // Full chain stalled, flush the middle stage.
`ifdef PIPE_COLLAPSE_EN
        drain_exp[0] = 16'h0011; drain_exp[1] = 16'h0013; drain_exp[2] = 16'h0014; drain_exp[3] = 16'h0000;
`else
        drain_exp[0] = 16'h0011; drain_exp[1] = 16'h0000; drain_exp[2] = 16'h0013; drain_exp[3] = 16'h0000;
`endif
        do_reset();
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            bus.in_ctrl  = CW'(16'h0011 + c);
            bus.in_data  = DW'(c);
            @(posedge CLK); #1;
        end
        bus.in_valid = 1'b0;
        flush = 3'b010;
        @(negedge CLK);
        chk("f_occ_full", 64'(occupancy), 64'(3));
        chk("f_in_ready_during", 64'(bus.in_ready), 64'(0));
        @(posedge CLK); #1;
        flush = '0;
        bus.in_valid = 1'b1;
        bus.in_ctrl  = 16'h0014;
        @(negedge CLK);
        chk("f_occ_after", 64'(occupancy), 64'(2));
        chk("f_stage1_ctrl", 64'(u_dut.ctrl_reg[1]), 64'(0));
        chk("f_out_ctrl_held", 64'(bus.out_ctrl), 64'(16'h0011));
`ifdef PIPE_COLLAPSE_EN
        chk("f_in_ready_after", 64'(bus.in_ready), 64'(1));
`else
        chk("f_in_ready_after", 64'(bus.in_ready), 64'(0));
`endif
        @(posedge CLK); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk("f_drain_ctrl", 64'(bus.out_ctrl), 64'(drain_exp[c]));
            @(posedge CLK); #1;
        end

        // flush[0] blocks the input entirely.
        do_reset();
        bus.out_ready = 1'b1;
        flush = 3'b001;
        bus.in_valid = 1'b1;
        bus.in_ctrl  = 16'h0042;
        @(negedge CLK);
        chk("f0_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge CLK); #1;
        flush = '0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk("f0_occupancy", 64'(occupancy), 64'(0));
            chk("f0_out_valid", 64'(bus.out_valid), 64'(0));
            @(posedge CLK); #1;
        end

        // Halt entry followed by two more; input closes after the halt leaves.
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (c < 3) || (c >= 4);
            bus.in_ctrl  = (c == 0) ? 16'h8001 : ((c < 3) ? CW'(c + 1) : 16'h0004);
            @(negedge CLK);
            chk("h_out_ctrl", 64'(bus.out_ctrl),
                (c == 3) ? 64'(16'h8001) : (c == 4) ? 64'(2) : (c == 5) ? 64'(3) : 64'(0));
            chk("h_halted", 64'(halted), 64'(c >= 4));
            if (c >= 4) chk("h_in_ready", 64'(bus.in_ready), 64'(0));
            @(posedge CLK); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge CLK);
        #1 nRST = 1'b0;
        #1 chk("h_halted_cleared", 64'(halted), 64'(0));
        #1 nRST = 1'b1;

        // Async reset mid-stream with two resident entries.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = (c < 2);
            bus.in_ctrl  = CW'(16'h0031 + c);
            @(negedge CLK);
            if (c < 3) begin
                @(posedge CLK); #1;
            end
        end
        chk("r_occ_before", 64'(occupancy), 64'(2));
        chk("r_valid_before", 64'(bus.out_valid), 64'(1));
        #1 nRST = 1'b0;
        #1;
        chk("r_out_valid", 64'(bus.out_valid), 64'(0));
        chk("r_out_ctrl", 64'(bus.out_ctrl), 64'(0));
        chk("r_occupancy", 64'(occupancy), 64'(0));
        chk("r_halted", 64'(halted), 64'(0));
        #1 nRST = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_ctrl   = 16'h0077;
        bus.out_ready = 1'b1;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("r_resume_ctrl", 64'(bus.out_ctrl), (k == 2) ? 64'(16'h0077) : 64'(0));
            if (k < 2) begin
                @(posedge CLK); #1;
            end
        end

        // DEPTH=1: stalled entry holds, upstream blocked, single transfer on release.
        do_reset();
        xfers = 0;
        for (int c = 0; c < 9; c++) begin
            bus1.in_valid  = (c < 5);
            bus1.in_ctrl   = (c == 0) ? 16'h00A5 : 16'h005A;
            bus1.out_ready = (c >= 5);
            @(negedge CLK);
            if (c >= 1 && c <= 5) chk("d1_out_ctrl", 64'(bus1.out_ctrl), 64'(16'h00A5));
            if (c >= 1 && c <= 4) chk("d1_in_ready", 64'(bus1.in_ready), 64'(0));
            if (bus1.out_valid && bus1.out_ready) xfers++;
            @(posedge CLK); #1;
        end
        chk("d1_xfers", 64'(xfers), 64'(1));
        chk("d1_occupancy", 64'(occ1), 64'(0));

        // Randomized stream against the scoreboard.
        sb.delete();
        do_reset();
        sb_on = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            bus.in_valid  = ($urandom_range(9) < 7);
            bus.in_ctrl   = CW'($urandom) & ~(CW'(1) << HB);
            bus.in_data   = DW'($urandom);
            bus.out_ready = ($urandom_range(9) < 6);
            @(posedge CLK); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (D + 3) begin
            @(posedge CLK); #1;
        end
        sb_on = 1'b0;
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
